input_port_buffer: RTL and testbench
====================================

INPUT_PORT_BUFFER -- requirements
Module: input_port_buffer

Interface
REQ-001 Parameter FLIT_W, default 32, flit width in bits; FLIT_W >= 2*COORD_W+2.
REQ-002 Parameter DEPTH, default 4, FIFO depth in flits; power of two, >= 2.
REQ-003 Parameter COORD_W, default 4, width of each mesh coordinate.
REQ-004 Parameter X_CUR, default 0, X coordinate of this router.
REQ-005 Parameter Y_CUR, default 0, Y coordinate of this router.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 in_valid  input  1  upstream flit valid.
REQ-009 in_flit  input  FLIT_W  upstream flit.
REQ-010 in_ready  output  1  buffer accepts a flit this cycle.
REQ-011 req  output  5  one-hot request to output arbiters; bit 0 local, 1 north, 2 east, 3 south, 4 west.
REQ-012 gnt  input  5  grant from output arbiters, one bit per output port.
REQ-013 out_flit  output  FLIT_W  flit at FIFO head, to crossbar.
REQ-014 count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 drop_err  output  1  one-cycle pulse when a stray non-head flit is discarded.

Function
REQ-016 Flit type is in_flit[FLIT_W-1:FLIT_W-2]: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single (head and tail).
REQ-017 Head and single flits carry dest_x in [COORD_W-1:0] and dest_y in [2*COORD_W-1:COORD_W].
REQ-018 in_ready = !full && !rst; a push occurs when in_valid && in_ready.
REQ-019 FIFO is circular with wrap-around read/write pointers; push and pop in the same cycle leave count unchanged, including at count==DEPTH-1 and count==1.
REQ-020 out_flit is driven combinationally from the FIFO head entry; its value is don't-care when count==0.
REQ-021 FSM states: IDLE (no route locked) and ROUTED (route locked).
REQ-022 In IDLE with count>0 and a head or single flit at the FIFO head, compute the XY route, latch it into route, and go to ROUTED on the next edge; req stays 0 in IDLE.
REQ-023 XY routing: dest_x>X_CUR -> east; dest_x<X_CUR -> west; otherwise dest_y>Y_CUR -> north; dest_y<Y_CUR -> south; otherwise local; comparisons are unsigned.
REQ-024 In IDLE with a body or tail flit at the FIFO head, pop it, stay in IDLE, and pulse drop_err for exactly one cycle.
REQ-025 In ROUTED, req = route when count>0, else req = 0; route is held until the tail is sent.
REQ-026 A transfer (pop) occurs when (req & gnt) != 0; grant bits on unrequested ports are ignored.
REQ-027 A transfer of a tail or single flit returns the FSM to IDLE on the same edge; the next packet's head is routed no earlier than the following cycle, giving a minimum one-cycle req gap between packets.
REQ-028 A FIFO underflow in ROUTED (body flits not yet arrived) deasserts req and holds the route; no drop occurs.
REQ-029 Latency: a head pushed into an empty buffer at edge N raises req after edge N+1.

Reset
REQ-030 While rst is high at a rising edge: pointers=0, count=0, state=IDLE, route=0, drop_err=0; req=0 and in_ready=0 while rst is asserted.
REQ-031 Reset mid-packet discards all buffered flits and the locked route; after deassertion, behaviour is as from power-up, and a leading body or tail flit is dropped per REQ-024.

Verification
REQ-032 X_CUR=Y_CUR=1; push single flit with dest (3,0) -> req=5'b00100 (east) two edges after push; gnt=5'b00100 -> pop, count=0, req=0, FSM=IDLE.
REQ-033 DEPTH=4; push head(dest 1,1), body, body, tail with gnt=0 -> count=4, in_ready=0, req=5'b00001; assert gnt[0] for 4 cycles -> flits exit in order, req=0 after the tail, count=0.
REQ-034 Push body flit into an empty IDLE buffer -> drop_err high for exactly one cycle, count returns to 0, req stays 0.
REQ-035 Hold in_valid=1 with full FIFO and gnt continuously matching req -> one push and one pop every cycle, count stays at DEPTH-1 after the first drain, no flit lost across pointer wrap.
REQ-036 Route head to west, then assert gnt=5'b00011 (wrong ports) -> no pop, req stays 5'b10000; assert rst for one cycle mid-packet -> count=0, req=0, in_ready=1 in the cycle after rst falls.

Source files
------------

// File: rtl/input_port_buffer_if.sv
// Router input-port bundle: upstream flit handshake, arbiter req/gnt,
// crossbar data and buffer status.
interface input_port_buffer_if #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic [FLIT_W-1:0] in_flit;
  logic              in_ready;
  logic [4:0]        req;
  logic [4:0]        gnt;
  logic [FLIT_W-1:0] out_flit;
  logic [CNT_W-1:0]  count;
  logic              drop_err;

  modport slave (
    input  in_valid, in_flit, gnt,
    output in_ready, req, out_flit, count, drop_err
  );

  modport master (
    output in_valid, in_flit, gnt,
    input  in_ready, req, out_flit, count, drop_err
  );
endinterface

// File: rtl/input_port_buffer.sv
// Wormhole input buffer for a mesh router: circular flit FIFO plus an XY
// route lock that holds the output request from head flit until tail.
//
// state  | meaning
// IDLE   | no route locked; head flit is routed, stray body/tail is dropped
// ROUTED | route locked; request raised while flits are buffered
module input_port_buffer #(
  parameter int FLIT_W  = 32,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 4,
  parameter int X_CUR   = 0,
  parameter int Y_CUR   = 0
) (
  input logic                clk,
  input logic                rst,
  input_port_buffer_if.slave port
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [COORD_W-1:0] X_C = COORD_W'(X_CUR);
  localparam logic [COORD_W-1:0] Y_C = COORD_W'(Y_CUR);

  typedef enum logic [0:0] {IDLE, ROUTED} state_e;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  state_e            state_q;
  logic [4:0]        route_q, route_d;
  logic              drop_err_q;

  logic [FLIT_W-1:0]  head_flit;
  logic [1:0]         head_type;
  logic [COORD_W-1:0] dest_x, dest_y;
  logic               not_empty, full, push, pop, xfer, stray;
  logic [4:0]         req;

  assign head_flit = mem_q[rd_ptr_q];
  assign head_type = head_flit[FLIT_W-1:FLIT_W-2];
  assign dest_x    = head_flit[COORD_W-1:0];
  assign dest_y    = head_flit[2*COORD_W-1:COORD_W];

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_W'(DEPTH));

  assign port.in_ready = !full && !rst;
  assign push          = port.in_valid && !full && !rst;

  assign req   = (!rst && state_q == ROUTED && not_empty) ? route_q : 5'b0;
  assign xfer  = |(req & port.gnt);
  // Body/tail at the head with no route locked has no packet to belong to.
  assign stray = (state_q == IDLE) && not_empty && !head_type[1];
  assign pop   = xfer || stray;

  // XY dimension-order routing: resolve X first, then Y.
  always_comb begin
    route_d = 5'b0;
    if (dest_x > X_C)      route_d[2] = 1'b1;
    else if (dest_x < X_C) route_d[4] = 1'b1;
    else if (dest_y > Y_C) route_d[1] = 1'b1;
    else if (dest_y < Y_C) route_d[3] = 1'b1;
    else                   route_d[0] = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= port.in_flit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      route_q    <= 5'b0;
      drop_err_q <= 1'b0;
    end else begin
      drop_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (not_empty && head_type[1]) begin
            route_q <= route_d;
            state_q <= ROUTED;
          end else if (stray) begin
            drop_err_q <= 1'b1;
          end
        end
        ROUTED: begin
          if (xfer && head_type[0]) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign port.req      = req;
  assign port.out_flit = head_flit;
  assign port.count    = count_q;
  assign port.drop_err = drop_err_q;
endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer at router (1,1), DEPTH 4, 32-bit flits.
module tb_input_port_buffer;
  localparam logic [1:0] T_HEAD = 2'b10, T_BODY = 2'b00, T_TAIL = 2'b01, T_SING = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  input_port_buffer_if #(.FLIT_W(32), .DEPTH(4)) bus ();

  input_port_buffer #(
    .FLIT_W(32), .DEPTH(4), .COORD_W(4), .X_CUR(1), .Y_CUR(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .port(bus.slave)
  );

  function automatic logic [31:0] mk(input logic [1:0] t, input int dx, input int dy, input int pl);
    logic [21:0] p;
    logic [3:0]  x, y;
    p = pl[21:0];
    x = dx[3:0];
    y = dy[3:0];
    return {t, p, y, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_flit = '0; bus.gnt = '0;
    tick(); tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b want 0", bus.in_ready); end
    checks++; if (bus.req !== 5'b0) begin errors++; $display("FAIL rst_req got %b want 00000", bus.req); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", bus.count); end
    checks++; if (bus.drop_err !== 1'b0) begin errors++; $display("FAIL rst_drop got %0b want 0", bus.drop_err); end
    rst = 1'b0; #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_single_east();
    logic [31:0] f;
    f = mk(T_SING, 3, 0, 32'h155);
    bus.in_valid = 1'b1; bus.in_flit = f;
    tick();
    bus.in_valid = 1'b0; #1;
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL east_count1 got %0d want 1", bus.count); end
    checks++; if (bus.req !== 5'b0) begin errors++; $display("FAIL east_req_idle got %b want 00000", bus.req); end
    tick();
    checks++; if (bus.req !== 5'b00100) begin errors++; $display("FAIL east_req got %b want 00100", bus.req); end
    checks++; if (bus.out_flit !== f) begin errors++; $display("FAIL east_flit got %h want %h", bus.out_flit, f); end
    bus.gnt = 5'b00100;
    tick();
    bus.gnt = 5'b0; #1;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL east_count0 got %0d want 0", bus.count); end
    checks++; if (bus.req !== 5'b0) begin errors++; $display("FAIL east_req_done got %b want 00000", bus.req); end
    tick();
    checks++; if (bus.req !== 5'b0) begin errors++; $display("FAIL east_req_after got %b want 00000", bus.req); end
  endtask

  task automatic test_wormhole_local();
    logic [31:0] f [4];
    f[0] = mk(T_HEAD, 1, 1, 32'h10);
    f[1] = mk(T_BODY, 0, 0, 32'h11);
    f[2] = mk(T_BODY, 0, 0, 32'h12);
    f[3] = mk(T_TAIL, 0, 0, 32'h13);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_flit = f[i];
      tick();
    end
    bus.in_valid = 1'b0; #1;
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL worm_count got %0d want 4", bus.count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL worm_full_ready got %0b want 0", bus.in_ready); end
    checks++; if (bus.req !== 5'b00001) begin errors++; $display("FAIL worm_req got %b want 00001", bus.req); end
    bus.gnt = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.out_flit !== f[i]) begin errors++; $display("FAIL worm_order%0d got %h want %h", i, bus.out_flit, f[i]); end
      tick();
    end
    bus.gnt = 5'b0; #1;
    checks++; if (bus.req !== 5'b0) begin errors++; $display("FAIL worm_req_end got %b want 00000", bus.req); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL worm_count_end got %0d want 0", bus.count); end
  endtask

  task automatic test_drop();
    bus.in_valid = 1'b1; bus.in_flit = mk(T_BODY, 0, 0, 32'h77);
    tick();
    bus.in_valid = 1'b0; #1;
    checks++; if (bus.drop_err !== 1'b0) begin errors++; $display("FAIL drop_early got %0b want 0", bus.drop_err); end
    tick();
    checks++; if (bus.drop_err !== 1'b1) begin errors++; $display("FAIL drop_pulse got %0b want 1", bus.drop_err); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL drop_count got %0d want 0", bus.count); end
    checks++; if (bus.req !== 5'b0) begin errors++; $display("FAIL drop_req got %b want 00000", bus.req); end
    tick();
    checks++; if (bus.drop_err !== 1'b0) begin errors++; $display("FAIL drop_width got %0b want 0", bus.drop_err); end
  endtask

  task automatic test_routes();
    int          dx [4] = '{1, 1, 3, 0};
    int          dy [4] = '{3, 0, 3, 0};
    logic [4:0]  ex [4] = '{5'b00010, 5'b01000, 5'b00100, 5'b10000};
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_flit = mk(T_SING, dx[i], dy[i], 32'h200 + i);
      tick();
      bus.in_valid = 1'b0;
      tick();
      checks++; if (bus.req !== ex[i]) begin errors++; $display("FAIL route%0d got %b want %b", i, bus.req, ex[i]); end
      bus.gnt = ex[i];
      tick();
      bus.gnt = 5'b0; #1;
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL route%0d_count got %0d want 0", i, bus.count); end
    end
  endtask

  task automatic test_pkt_gap();
    bus.in_valid = 1'b1; bus.in_flit = mk(T_SING, 3, 1, 32'h300);
    tick();
    bus.in_flit = mk(T_SING, 1, 3, 32'h301);
    tick();
    bus.in_valid = 1'b0; bus.gnt = 5'b11111; #1;
    checks++; if (bus.req !== 5'b00100) begin errors++; $display("FAIL gap_reqA got %b want 00100", bus.req); end
    tick();
    checks++; if (bus.req !== 5'b0) begin errors++; $display("FAIL gap_idle got %b want 00000", bus.req); end
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL gap_count got %0d want 1", bus.count); end
    tick();
    checks++; if (bus.req !== 5'b00010) begin errors++; $display("FAIL gap_reqB got %b want 00010", bus.req); end
    tick();
    bus.gnt = 5'b0; #1;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL gap_count_end got %0d want 0", bus.count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] f [10];
    logic [2:0]  exp_cnt;
    f[0] = mk(T_HEAD, 3, 1, 32'h400);
    for (int i = 1; i < 9; i++) f[i] = mk(T_BODY, 0, 0, 32'h400 + i);
    f[9] = mk(T_TAIL, 0, 0, 32'h409);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_flit = f[i];
      tick();
    end
    #1;
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL b2b_full got %0d want 4", bus.count); end
    bus.gnt = 5'b00100;
    for (int c = 0; c < 10; c++) begin
      if (c >= 1 && 3 + c <= 9) begin
        bus.in_valid = 1'b1; bus.in_flit = f[3 + c];
      end else if (c >= 1) begin
        bus.in_valid = 1'b0;
      end
      #1;
      exp_cnt = (c == 0) ? 3'd4 : (c <= 7) ? 3'd3 : (c == 8) ? 3'd2 : 3'd1;
      checks++; if (bus.count !== exp_cnt) begin errors++; $display("FAIL b2b_count%0d got %0d want %0d", c, bus.count, exp_cnt); end
      checks++; if (bus.out_flit !== f[c]) begin errors++; $display("FAIL b2b_flit%0d got %h want %h", c, bus.out_flit, f[c]); end
      tick();
    end
    bus.in_valid = 1'b0; bus.gnt = 5'b0; #1;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL b2b_count_end got %0d want 0", bus.count); end
    checks++; if (bus.req !== 5'b0) begin errors++; $display("FAIL b2b_req_end got %b want 00000", bus.req); end
  endtask

  task automatic test_wrong_gnt_reset();
    bus.in_valid = 1'b1; bus.in_flit = mk(T_HEAD, 0, 1, 32'h500);
    tick();
    bus.in_flit = mk(T_BODY, 0, 0, 32'h501);
    tick();
    bus.in_valid = 1'b0; bus.gnt = 5'b00011;
    tick(); tick();
    checks++; if (bus.req !== 5'b10000) begin errors++; $display("FAIL wgnt_req got %b want 10000", bus.req); end
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL wgnt_count got %0d want 2", bus.count); end
    rst = 1'b1; #1;
    checks++; if (bus.req !== 5'b0) begin errors++; $display("FAIL midrst_req got %b want 00000", bus.req); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %0b want 0", bus.in_ready); end
    tick();
    rst = 1'b0; bus.gnt = 5'b0; #1;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", bus.count); end
    checks++; if (bus.req !== 5'b0) begin errors++; $display("FAIL midrst_req_after got %b want 00000", bus.req); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after got %0b want 1", bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_flit = mk(T_TAIL, 0, 0, 32'h502);
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.drop_err !== 1'b1) begin errors++; $display("FAIL midrst_drop got %0b want 1", bus.drop_err); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL midrst_drop_count got %0d want 0", bus.count); end
  endtask

  initial begin
    test_reset();
    test_single_east();
    test_wormhole_local();
    test_drop();
    test_routes();
    test_pkt_gap();
    test_back_to_back();
    test_wrong_gnt_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
